cpx_dest_arb: RTL

- Per-destination CPX arbiter: one instance per SPARC core destination, sharing that core's CPX return path among NSRC sources (4 L2 banks, IOB, FPU).
- Tracks per-source queued packet counts and picks one source per cycle, round-robin.
- Atomic packet pairs are granted back-to-back without interleaving.
- Produces the one-hot mux select and the data-ready bit consumed by the cx→cx2 data/ready flop stage.

---
 rtl/cpx_dest_arb.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/cpx_dest_arb.sv
// Per-destination CPX return-path arbiter: counts queued packets per source,
// grants one source per cycle round-robin, and keeps atomic pairs back-to-back.
module cpx_dest_arb #(
  parameter int NSRC   = 6,
  parameter int QDEPTH = 2,
  parameter int CW     = 2
) (
  input  logic            rclk,
  input  logic            arst_l,
  input  logic [NSRC-1:0] src_req_pq,
  input  logic [NSRC-1:0] src_atom_pq,
  input  logic            dest_stall,
  output logic [NSRC-1:0] arb_grant_cx,
  output logic            arb_data_rdy_cx,
  output logic            arb_atom_cx,
  output logic [NSRC-1:0] arb_qfull_pq,
  output logic            arb_ovfl_err
);

  localparam int PW = (NSRC > 1) ? $clog2(NSRC) : 1;

  typedef enum logic {ST_ARB, ST_LOCK} state_t;

  state_t              r_state,    w_state_nxt;
  logic [PW-1:0]       r_rr_ptr,   w_rr_nxt;
  logic [PW-1:0]       r_lock_src, w_lock_nxt;
  logic [CW-1:0]       r_cnt     [NSRC];
  logic [CW-1:0]       w_cnt_nxt [NSRC];
  logic [QDEPTH-1:0]   r_tag     [NSRC];
  logic [QDEPTH-1:0]   w_tag_nxt [NSRC];
  logic [NSRC-1:0]     w_grant;
  logic                w_atom;
  logic                w_found;
  logic                w_lock_err;
  logic                w_ovfl;
  int                  w_idx;

  always_comb begin
    for (int i = 0; i < NSRC; i++) arb_qfull_pq[i] = (r_cnt[i] == CW'(QDEPTH));
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_grant     = '0;
    w_atom      = 1'b0;
    w_found     = 1'b0;
    w_lock_err  = 1'b0;
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr_ptr;
    w_lock_nxt  = r_lock_src;
    w_idx       = 0;
    case (r_state)
      ST_ARB: begin
        if (!dest_stall) begin
          for (int k = 0; k < NSRC; k++) begin
            w_idx = (int'(r_rr_ptr) + k) % NSRC;
            if (!w_found && r_cnt[w_idx] != '0) begin
              w_found        = 1'b1;
              w_grant[w_idx] = 1'b1;
              w_rr_nxt       = PW'((w_idx + 1) % NSRC);
              if (r_tag[w_idx][0]) begin
                w_atom      = 1'b1;
                w_state_nxt = ST_LOCK;
                w_lock_nxt  = PW'(w_idx);
              end
            end
          end
        end
      end
      ST_LOCK: begin
        // An empty lock source means the pair was corrupted; flag it and unlock.
        if (r_cnt[r_lock_src] == '0) begin
          w_lock_err  = 1'b1;
          w_state_nxt = ST_ARB;
        end else if (!dest_stall) begin
          w_grant[r_lock_src] = 1'b1;
          w_state_nxt         = ST_ARB;
        end
      end
      default: w_state_nxt = ST_ARB;
    endcase
  end

  // Counter and tag update: pop the granted head, then append new tags behind it.
  always_comb begin
    logic [CW+1:0]     base;
    logic [CW+1:0]     sum;
    logic [1:0]        add;
    logic [QDEPTH-1:0] t;
    w_ovfl = 1'b0;
    base   = '0;
    sum    = '0;
    add    = '0;
    t      = '0;
    for (int i = 0; i < NSRC; i++) begin
      add  = src_req_pq[i] ? (src_atom_pq[i] ? 2'd2 : 2'd1) : 2'd0;
      base = {2'b00, r_cnt[i]} - {{(CW+1){1'b0}}, w_grant[i]};
      sum  = base + {{CW{1'b0}}, add};
      if (sum > (CW+2)'(QDEPTH)) begin
        w_ovfl = 1'b1;
        add    = 2'd0;
      end
      t = w_grant[i] ? (r_tag[i] >> 1) : r_tag[i];
      if (add == 2'd1 && base < (CW+2)'(QDEPTH)) t[base] = 1'b0;
      if (add == 2'd2 && base + 1 < (CW+2)'(QDEPTH)) begin
        t[base]   = 1'b1;
        t[base+1] = 1'b0;
      end
      w_tag_nxt[i] = t;
      w_cnt_nxt[i] = CW'(base + {{CW{1'b0}}, add});
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      r_state         <= ST_ARB;
      r_rr_ptr        <= '0;
      r_lock_src      <= '0;
      arb_grant_cx    <= '0;
      arb_data_rdy_cx <= 1'b0;
      arb_atom_cx     <= 1'b0;
      arb_ovfl_err    <= 1'b0;
      // NOTE: the tag store is a few flops, so it is reset along with the counters.
      for (int i = 0; i < NSRC; i++) begin
        r_cnt[i] <= '0;
        r_tag[i] <= '0;
      end
    end else begin
      r_state         <= w_state_nxt;
      r_rr_ptr        <= w_rr_nxt;
      r_lock_src      <= w_lock_nxt;
      arb_grant_cx    <= w_grant;
      arb_data_rdy_cx <= |w_grant;
      arb_atom_cx     <= w_atom;
      arb_ovfl_err    <= arb_ovfl_err | w_ovfl | w_lock_err;
      for (int i = 0; i < NSRC; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
        r_tag[i] <= w_tag_nxt[i];
      end
    end
  end

endmodule
